// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
// Default widths/depths are reused by the surrounding design.
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bundle for sync_fifo.
// master: drives W_INC/WR_DATA/R_INC/CLR_ERR; slave: the FIFO.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
  localparam int CW = clog2(FIFO_DEPTH) + 1;

  logic                  W_INC;
  logic [DATA_WIDTH-1:0] WR_DATA;
  logic                  R_INC;
  logic                  CLR_ERR;
  logic [DATA_WIDTH-1:0] RD_DATA;
  logic                  RD_VALID;
  logic                  FULL;
  logic                  EMPTY;
  logic                  ALMOST_FULL;
  logic                  ALMOST_EMPTY;
  logic [CW-1:0]         COUNT;
  logic                  OVERFLOW;
  logic                  UNDERFLOW;

  modport master (
    output W_INC, WR_DATA, R_INC, CLR_ERR,
    input  RD_DATA, RD_VALID, FULL, EMPTY,
    input  ALMOST_FULL, ALMOST_EMPTY, COUNT,
    input  OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  W_INC, WR_DATA, R_INC, CLR_ERR,
    output RD_DATA, RD_VALID, FULL, EMPTY,
    output ALMOST_FULL, ALMOST_EMPTY, COUNT,
    output OVERFLOW, UNDERFLOW
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: DATA_WIDTH x FIFO_DEPTH regs, sync write, async read.
// Ports: CLK, we, wr_addr, wr_data, rd_addr, rd_data.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ADDR_WIDTH = clog2(FIFO_DEPTH)
) (
  input  logic                  CLK,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: any depth, count, thresholds, sticky errors.
// Ports: CLK, RST (sync, high), bus (sync_fifo_if.slave).
// SYNC_FIFO_FWFT_EN selects first-word-fall-through read.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input logic        CLK,
  input logic        RST,
  sync_fifo_if.slave bus
);

  localparam int ADDR_WIDTH = clog2(FIFO_DEPTH);
  localparam int CW = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C = CW'(AE_LEVEL);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;
  logic                  full;
  logic                  empty;
  logic                  af;
  logic                  ae;
  logic                  ovf;
  logic                  unf;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] head;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [ADDR_WIDTH-1:0] bump(
    input logic [ADDR_WIDTH-1:0] p
  );
    return (p == LAST) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  assign wr_acc = bus.W_INC & ~full;
  assign rd_acc = bus.R_INC & ~empty;

  assign count_nxt = count + CW'(wr_acc) - CW'(rd_acc);

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .CLK     (CLK),
    .we      (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (bus.WR_DATA),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  // Flags come from count_nxt so they line up with COUNT.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      af     <= 1'b0;
      ae     <= 1'b1;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= bump(wr_ptr);
      if (rd_acc) rd_ptr <= bump(rd_ptr);
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
      af    <= (count_nxt >= AF_C);
      ae    <= (count_nxt <= AE_C);
      // New violation wins over a same-cycle clear.
      ovf <= (ovf & ~bus.CLR_ERR) | (bus.W_INC & full);
      unf <= (unf & ~bus.CLR_ERR) | (bus.R_INC & empty);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.RD_DATA  = head;
  assign bus.RD_VALID = ~empty;
`else
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (rd_acc) rd_data_q <= head;
      rd_valid_q <= rd_acc;
    end
  end

  assign bus.RD_DATA  = rd_data_q;
  assign bus.RD_VALID = rd_valid_q;
`endif

  assign bus.FULL         = full;
  assign bus.EMPTY        = empty;
  assign bus.ALMOST_FULL  = af;
  assign bus.ALMOST_EMPTY = ae;
  assign bus.COUNT        = count;
  assign bus.OVERFLOW     = ovf;
  assign bus.UNDERFLOW    = unf;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: depth 8 and depth 5 instances.
// Builds with or without SYNC_FIFO_FWFT_EN.
module tb_sync_fifo;

  logic clk;
  logic rst;

  int checks;
  int failures;

  sync_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(8)) bus8 ();
  sync_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(5)) bus5 ();

  sync_fifo #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (8)
  ) u_dut8 (
    .CLK (clk),
    .RST (rst),
    .bus (bus8)
  );

  sync_fifo #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (5)
  ) u_dut5 (
    .CLK (clk),
    .RST (rst),
    .bus (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push8(input logic [7:0] d);
    bus8.W_INC   = 1'b1;
    bus8.WR_DATA = d;
    tick();
    bus8.W_INC   = 1'b0;
  endtask

  // Issues a read on one instance and checks the popped word.
  // R_INC is left high so callers can stream reads.
  task automatic pop(
    input int         sel,
    input string      tag,
    input logic [7:0] exp
  );
    if (sel == 5) bus5.R_INC = 1'b1;
    else bus8.R_INC = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
    if (sel == 5) begin
      check({tag, "_head"}, 32'(bus5.RD_DATA), 32'(exp));
      check({tag, "_vld"}, 32'(bus5.RD_VALID), 32'd1);
    end else begin
      check({tag, "_head"}, 32'(bus8.RD_DATA), 32'(exp));
      check({tag, "_vld"}, 32'(bus8.RD_VALID), 32'd1);
    end
    tick();
`else
    tick();
    if (sel == 5) begin
      check({tag, "_data"}, 32'(bus5.RD_DATA), 32'(exp));
      check({tag, "_vld"}, 32'(bus5.RD_VALID), 32'd1);
    end else begin
      check({tag, "_data"}, 32'(bus8.RD_DATA), 32'(exp));
      check({tag, "_vld"}, 32'(bus8.RD_VALID), 32'd1);
    end
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus8.W_INC = 1'b0;
    bus8.WR_DATA = '0;
    bus8.R_INC = 1'b0;
    bus8.CLR_ERR = 1'b0;
    bus5.W_INC = 1'b0;
    bus5.WR_DATA = '0;
    bus5.R_INC = 1'b0;
    bus5.CLR_ERR = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_count", 32'(bus8.COUNT), 32'd0);
    check("rst_empty", 32'(bus8.EMPTY), 32'd1);
    check("rst_ae", 32'(bus8.ALMOST_EMPTY), 32'd1);
    check("rst_full", 32'(bus8.FULL), 32'd0);
    check("rst_af", 32'(bus8.ALMOST_FULL), 32'd0);
    check("rst_ovf", 32'(bus8.OVERFLOW), 32'd0);
    check("rst_unf", 32'(bus8.UNDERFLOW), 32'd0);
    check("rst_vld", 32'(bus8.RD_VALID), 32'd0);
    check("rst_data", 32'(bus8.RD_DATA), 32'd0);

    // Fill to full, then overflow.
    for (int i = 1; i <= 8; i++) begin
      push8(8'(i));
      check("fill_count", 32'(bus8.COUNT), 32'(i));
      check("fill_full", 32'(bus8.FULL), 32'(i == 8));
      check("fill_af", 32'(bus8.ALMOST_FULL), 32'(i >= 7));
      check("fill_ae", 32'(bus8.ALMOST_EMPTY), 32'(i <= 1));
      check("fill_empty", 32'(bus8.EMPTY), 32'd0);
    end
    push8(8'hFF);
    check("ovf_set", 32'(bus8.OVERFLOW), 32'd1);
    check("ovf_count", 32'(bus8.COUNT), 32'd8);

    // Back-to-back drain in order.
    for (int i = 1; i <= 8; i++) begin
      pop(8, "drain", 8'(i));
    end
    check("drain_empty", 32'(bus8.EMPTY), 32'd1);
    check("drain_count", 32'(bus8.COUNT), 32'd0);
    tick();
    bus8.R_INC = 1'b0;
    check("unf_set", 32'(bus8.UNDERFLOW), 32'd1);
    check("unf_vld", 32'(bus8.RD_VALID), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    check("unf_hold", 32'(bus8.RD_DATA), 32'h08);
`endif
    bus8.CLR_ERR = 1'b1;
    tick();
    bus8.CLR_ERR = 1'b0;
    check("clr_ovf", 32'(bus8.OVERFLOW), 32'd0);
    check("clr_unf", 32'(bus8.UNDERFLOW), 32'd0);

    // Simultaneous request while full.
    for (int i = 0; i < 8; i++) push8(8'(8'h10 + i));
    check("full2", 32'(bus8.FULL), 32'd1);
    bus8.W_INC = 1'b1;
    bus8.WR_DATA = 8'hEE;
    pop(8, "both_full", 8'h10);
    bus8.W_INC = 1'b0;
    bus8.R_INC = 1'b0;
    check("both_full_count", 32'(bus8.COUNT), 32'd7);
    check("both_full_ovf", 32'(bus8.OVERFLOW), 32'd1);
    check("both_full_nf", 32'(bus8.FULL), 32'd0);
    for (int i = 1; i < 8; i++) begin
      pop(8, "rest", 8'(8'h10 + i));
    end
    bus8.R_INC = 1'b0;
    check("rest_empty", 32'(bus8.EMPTY), 32'd1);
    bus8.CLR_ERR = 1'b1;
    tick();
    bus8.CLR_ERR = 1'b0;

    // Simultaneous request while empty.
    bus8.W_INC = 1'b1;
    bus8.WR_DATA = 8'h77;
    bus8.R_INC = 1'b1;
    tick();
    bus8.W_INC = 1'b0;
    bus8.R_INC = 1'b0;
    check("both_empty_count", 32'(bus8.COUNT), 32'd1);
    check("both_empty_unf", 32'(bus8.UNDERFLOW), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
    check("both_empty_vld", 32'(bus8.RD_VALID), 32'd1);
`else
    check("both_empty_vld", 32'(bus8.RD_VALID), 32'd0);
`endif
    pop(8, "empty_word", 8'h77);
    bus8.R_INC = 1'b0;

    // Reset mid-stream.
    bus8.CLR_ERR = 1'b1;
    tick();
    bus8.CLR_ERR = 1'b0;
    for (int i = 0; i < 4; i++) push8(8'(8'h50 + i));
    bus8.W_INC = 1'b1;
    bus8.WR_DATA = 8'h99;
    bus8.R_INC = 1'b1;
    tick();
    bus8.W_INC = 1'b0;
    bus8.R_INC = 1'b0;
    check("pre_rst_count", 32'(bus8.COUNT), 32'd4);
    bus8.R_INC = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus8.R_INC = 1'b0;
    check("pre_rst_unf", 32'(bus8.UNDERFLOW), 32'd1);
    for (int i = 0; i < 4; i++) push8(8'(8'h60 + i));
    check("pre_rst_count2", 32'(bus8.COUNT), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_count", 32'(bus8.COUNT), 32'd0);
    check("mrst_empty", 32'(bus8.EMPTY), 32'd1);
    check("mrst_unf", 32'(bus8.UNDERFLOW), 32'd0);
    check("mrst_vld", 32'(bus8.RD_VALID), 32'd0);
    check("mrst_data", 32'(bus8.RD_DATA), 32'd0);
    push8(8'hA5);
    pop(8, "after_rst", 8'hA5);
    bus8.R_INC = 1'b0;

`ifdef SYNC_FIFO_FWFT_EN
    // Fall-through: head visible without R_INC.
    push8(8'h3C);
    check("fwft_data", 32'(bus8.RD_DATA), 32'h3C);
    check("fwft_vld", 32'(bus8.RD_VALID), 32'd1);
    bus8.R_INC = 1'b1;
    tick();
    bus8.R_INC = 1'b0;
    check("fwft_drop", 32'(bus8.RD_VALID), 32'd0);
`endif

    // Depth 5: 4 preloaded, 16 streamed, 4 drained.
    for (int i = 0; i < 4; i++) begin
      bus5.W_INC = 1'b1;
      bus5.WR_DATA = 8'(8'h20 + i);
      tick();
    end
    bus5.W_INC = 1'b0;
    check("d5_count4", 32'(bus5.COUNT), 32'd4);
    check("d5_af", 32'(bus5.ALMOST_FULL), 32'd1);
    for (int j = 0; j < 16; j++) begin
      bus5.W_INC = 1'b1;
      bus5.WR_DATA = 8'(8'h24 + j);
      pop(5, "d5_stream", 8'(8'h20 + j));
      check("d5_stream_count", 32'(bus5.COUNT), 32'd4);
    end
    bus5.W_INC = 1'b0;
    for (int j = 16; j < 20; j++) begin
      pop(5, "d5_drain", 8'(8'h20 + j));
    end
    bus5.R_INC = 1'b0;
    check("d5_empty", 32'(bus5.EMPTY), 32'd1);
    check("d5_ovf", 32'(bus5.OVERFLOW), 32'd0);
    for (int i = 0; i < 6; i++) begin
      bus5.W_INC = 1'b1;
      bus5.WR_DATA = 8'(8'h40 + i);
      tick();
    end
    bus5.W_INC = 1'b0;
    check("d5_full", 32'(bus5.FULL), 32'd1);
    check("d5_count5", 32'(bus5.COUNT), 32'd5);
    check("d5_ovf_set", 32'(bus5.OVERFLOW), 32'd1);
    pop(5, "d5_first", 8'h40);
    bus5.R_INC = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
